lsu_mem_arbiter: RTL and testbench

Arbitrates the per-thread load/store requests from one `core` onto a single shared data-memory port and returns read data and completion handshakes to each thread. It sits directly downstream of the core's flattened LSU interface (`lsu_*_flat`) and directly upstream of data memory. One memory transaction is outstanding at a time. Threads are served round-robin.

---
 rtl/lsu_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter of per-thread LSU requests onto one data-memory port, one transaction in flight.
// Issue 1 cycle after request; completion held on lsu_ready_flat until the thread drops its valids.
module lsu_mem_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         lsu_read_valid_flat,
  input  logic [NUM_THREADS-1:0]         lsu_write_valid_flat,
  input  logic [NUM_THREADS*ADDR_BITS-1:0] lsu_read_addr_flat,
  input  logic [NUM_THREADS*ADDR_BITS-1:0] lsu_write_addr_flat,
  input  logic [NUM_THREADS*DATA_BITS-1:0] lsu_write_data_flat,
  output logic [NUM_THREADS-1:0]         lsu_ready_flat,
  output logic [NUM_THREADS*DATA_BITS-1:0] lsu_read_data_flat,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_addr,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_addr,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic                           mem_busy
);

  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]       sel;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand;
  logic [PTR_W-1:0]       sel_inc;
  logic                   grant_found;
  logic [NUM_THREADS-1:0] pending;

  assign pending  = lsu_read_valid_flat | lsu_write_valid_flat;
  assign sel_inc  = PTR_W'((int'(sel) + 1) % NUM_THREADS);
  assign mem_busy = (state != IDLE);

  // First pending thread at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_THREADS);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = lsu_read_valid_flat[grant_idx] ? READ_WAIT : WRITE_WAIT;
        end
      end
      READ_WAIT:  if (mem_read_ready)  state_nxt = RELAY;
      WRITE_WAIT: if (mem_write_ready) state_nxt = RELAY;
      RELAY:      if (!pending[sel])   state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel                <= '0;
      rr_ptr             <= '0;
      lsu_ready_flat     <= '0;
      lsu_read_data_flat <= '0;
      mem_read_valid     <= 1'b0;
      mem_read_addr      <= '0;
      mem_write_valid    <= 1'b0;
      mem_write_addr     <= '0;
      mem_write_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            sel <= grant_idx;
            if (lsu_read_valid_flat[grant_idx]) begin
              mem_read_valid <= 1'b1;
              mem_read_addr  <= lsu_read_addr_flat[grant_idx*ADDR_BITS +: ADDR_BITS];
            end else begin
              mem_write_valid <= 1'b1;
              mem_write_addr  <= lsu_write_addr_flat[grant_idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data  <= lsu_write_data_flat[grant_idx*DATA_BITS +: DATA_BITS];
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                               <= 1'b0;
            lsu_read_data_flat[sel*DATA_BITS +: DATA_BITS] <= mem_read_data;
            lsu_ready_flat[sel]                          <= 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid     <= 1'b0;
            lsu_ready_flat[sel] <= 1'b1;
          end
        end
        RELAY: begin
          // Ready stays up until the thread lets go, so a lingering valid is never re-granted.
          if (!pending[sel]) begin
            lsu_ready_flat <= '0;
            rr_ptr         <= sel_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench: rounds of thread requests against a randomly delaying memory; expected grants
// come from a cyclic-order model of the pending set.
module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  lsu_read_valid_flat = '0;
  logic [3:0]  lsu_write_valid_flat = '0;
  logic [31:0] lsu_read_addr_flat = '0;
  logic [31:0] lsu_write_addr_flat = '0;
  logic [31:0] lsu_write_data_flat = '0;
  logic [3:0]  lsu_ready_flat;
  logic [31:0] lsu_read_data_flat;
  logic        mem_read_valid;
  logic [7:0]  mem_read_addr;
  logic        mem_read_ready = 1'b0;
  logic [7:0]  mem_read_data = '0;
  logic        mem_write_valid;
  logic [7:0]  mem_write_addr;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready = 1'b0;
  logic        mem_busy;

  lsu_mem_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .lsu_read_valid_flat  (lsu_read_valid_flat),
    .lsu_write_valid_flat (lsu_write_valid_flat),
    .lsu_read_addr_flat   (lsu_read_addr_flat),
    .lsu_write_addr_flat  (lsu_write_addr_flat),
    .lsu_write_data_flat  (lsu_write_data_flat),
    .lsu_ready_flat       (lsu_ready_flat),
    .lsu_read_data_flat   (lsu_read_data_flat),
    .mem_read_valid       (mem_read_valid),
    .mem_read_addr        (mem_read_addr),
    .mem_read_ready       (mem_read_ready),
    .mem_read_data        (mem_read_data),
    .mem_write_valid      (mem_write_valid),
    .mem_write_addr       (mem_write_addr),
    .mem_write_data       (mem_write_data),
    .mem_write_ready      (mem_write_ready),
    .mem_busy             (mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         thread;
    bit         is_read;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  bit          cur_vld = 1'b0;
  logic [31:0] lanes_model = '0;
  int          model_ptr = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          mem_auto = 1'b1;
  int          pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory: random 0..3 cycle latency, read data = addr + 0x80, stray readies on the other channel.
  initial begin
    int wcnt = -1;
    int pulse_seen = 0;
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 8'($urandom);
      if (pulse_cnt != pulse_seen) begin
        pulse_seen      = pulse_cnt;
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        mem_read_data   = 8'h77;
      end else if (mem_auto) begin
        if (mem_read_valid || mem_write_valid) begin
          if (wcnt < 0) wcnt = $urandom_range(0, 3);
          if (wcnt == 0) begin
            wcnt = -1;
            if (mem_read_valid) begin
              mem_read_ready = 1'b1;
              mem_read_data  = mem_read_addr + 8'h80;
            end else begin
              mem_write_ready = 1'b1;
            end
          end else begin
            wcnt--;
          end
          if ($urandom_range(0, 3) == 0) begin
            if (mem_read_valid) mem_write_ready = 1'b1;
            else                mem_read_ready  = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          mem_read_ready  = 1'b1;
          mem_write_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new memory request and checks each completion.
  initial begin
    logic       prev_rv = 1'b0;
    logic       prev_wv = 1'b0;
    logic [3:0] prev_rdy = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("ready_onehot", 32'($onehot0(lsu_ready_flat)), 32'd1);
        chk("mem_valid_exclusive", 32'(mem_read_valid & mem_write_valid), 32'd0);
        if (mem_read_valid || mem_write_valid || (lsu_ready_flat != 0))
          chk("busy_active", 32'(mem_busy), 32'd1);
        if ((mem_read_valid && !prev_rv) || (mem_write_valid && !prev_wv)) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_mem_request");
          end else begin
            cur     = exp_q.pop_front();
            cur_vld = 1'b1;
            chk("req_is_read", 32'(mem_read_valid), 32'(cur.is_read));
            if (cur.is_read) begin
              chk("req_read_addr", 32'(mem_read_addr), 32'(cur.addr));
            end else begin
              chk("req_write_addr", 32'(mem_write_addr), 32'(cur.addr));
              chk("req_write_data", 32'(mem_write_data), 32'(cur.data));
            end
          end
        end
        if ((lsu_ready_flat != 0) && (prev_rdy == 0)) begin
          if (!cur_vld) begin
            fail_now("unexpected_ready");
          end else begin
            chk("ready_thread", 32'(lsu_ready_flat), 32'(4'b0001 << cur.thread));
            if (cur.is_read) lanes_model[cur.thread*8 +: 8] = cur.addr + 8'h80;
            chk("read_lanes", lsu_read_data_flat, lanes_model);
            cur_vld = 1'b0;
          end
        end
      end
      prev_rv  = mem_read_valid;
      prev_wv  = mem_write_valid;
      prev_rdy = lsu_ready_flat;
    end
  end

  task automatic run_round(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] ra,
                           input logic [31:0] wa, input logic [31:0] wd, input logic [15:0] holds);
    logic [3:0] pend;
    logic [3:0] done;
    logic [3:0] seen;
    int         hold[4];
    int         budget;
    int         last;
    txn_t       e;
    pend = rd | wr;
    done = ~pend;
    seen = '0;
    last = -1;
    for (int t = 0; t < 4; t++) hold[t] = int'(holds[t*4 +: 4]);
    // All requests are raised together, so service follows cyclic order from the pointer.
    for (int k = 0; k < 4; k++) begin
      int t = (model_ptr + k) % 4;
      if (pend[t]) begin
        e.thread  = t;
        e.is_read = rd[t];
        e.addr    = rd[t] ? ra[t*8 +: 8] : wa[t*8 +: 8];
        e.data    = wd[t*8 +: 8];
        exp_q.push_back(e);
        last = t;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % 4;

    @(negedge clk);
    lsu_read_addr_flat  = $urandom;
    lsu_write_addr_flat = $urandom;
    lsu_write_data_flat = $urandom;
    for (int t = 0; t < 4; t++) begin
      if (pend[t]) begin
        lsu_read_addr_flat[t*8 +: 8]  = ra[t*8 +: 8];
        lsu_write_addr_flat[t*8 +: 8] = wa[t*8 +: 8];
        lsu_write_data_flat[t*8 +: 8] = wd[t*8 +: 8];
      end
    end
    lsu_read_valid_flat  = rd;
    lsu_write_valid_flat = wr;

    budget = 0;
    while (done != 4'hF && budget < 300) begin
      @(negedge clk);
      budget++;
      for (int t = 0; t < 4; t++) begin
        if (!done[t]) begin
          if (seen[t]) chk("ready_held", 32'(lsu_ready_flat[t]), 32'd1);
          if (lsu_ready_flat[t]) begin
            seen[t] = 1'b1;
            if (hold[t] == 0) begin
              lsu_read_valid_flat[t]  = 1'b0;
              lsu_write_valid_flat[t] = 1'b0;
              done[t] = 1'b1;
            end else begin
              hold[t]--;
            end
          end
        end else begin
          lsu_read_addr_flat[t*8 +: 8]  = 8'($urandom);
          lsu_write_addr_flat[t*8 +: 8] = 8'($urandom);
          lsu_write_data_flat[t*8 +: 8] = 8'($urandom);
        end
      end
    end
    if (done != 4'hF) begin
      fail_now("round_timeout");
      lsu_read_valid_flat  = '0;
      lsu_write_valid_flat = '0;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("ready_released", 32'(lsu_ready_flat), 32'd0);
    chk("busy_idle", 32'(mem_busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(lsu_ready_flat), 32'd0);
    chk("rst_rdata", lsu_read_data_flat, 32'd0);
    chk("rst_mem_valids", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    chk("rst_mem_addrs", 32'({mem_read_addr, mem_write_addr, mem_write_data}), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    mon_en = 1'b1;

    // All four read 0x00+i from pointer 0, single load, single store, repeat all-four from pointer 2.
    run_round(4'b1111, 4'b0000, 32'h03020100, '0, '0, '0);
    run_round(4'b0100, 4'b0000, 32'h00100000, '0, '0, '0);
    run_round(4'b0000, 4'b0010, '0, 32'h00002000, 32'h00003C00, '0);
    run_round(4'b1111, 4'b0000, 32'h03020100, '0, '0, '0);
    // Thread 0 holds its valid 5 cycles past ready while thread 1 waits.
    run_round(4'b0011, 4'b0000, 32'h00005150, '0, '0, 16'h0005);
    // Read wins over write on the same thread.
    run_round(4'b1000, 4'b1000, 32'h40000000, 32'h41000000, 32'h99000000, '0);

    for (int r = 0; r < 40; r++) begin
      run_round(4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 16'($urandom) & 16'h3333);
    end

    // Reset while a read is outstanding, then a late memory ready.
    mon_en   = 1'b0;
    mem_auto = 1'b0;
    @(negedge clk);
    lsu_read_addr_flat[7:0] = 8'h33;
    lsu_read_valid_flat     = 4'b0001;
    begin
      int n = 0;
      while (!mem_read_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    chk("midop_read_issued", 32'(mem_read_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lsu_read_valid_flat = '0;
    @(posedge clk);
    #1 pulse_cnt++;
    @(negedge clk);
    @(negedge clk);
    chk("midop_ready", 32'(lsu_ready_flat), 32'd0);
    chk("midop_rdata", lsu_read_data_flat, 32'd0);
    chk("midop_mem_valids", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    chk("midop_mem_addrs", 32'({mem_read_addr, mem_write_addr, mem_write_data}), 32'd0);
    chk("midop_busy", 32'(mem_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("midop_still_idle", 32'({mem_busy, mem_read_valid, lsu_ready_flat}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
